mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 18, memory word-address width.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter MAX_WAIT, default 4, consecutive fetch denials before fetch is forced to win.
REQ-004 Port i_clk  in  1  single clock; all logic on its rising edge.
REQ-005 Port i_rst_n  in  1  synchronous, active-low reset.
REQ-006 Ports i_h_valid, i_h_we (in, 1), i_h_addr (in, ADDR_W), i_h_wdata (in, DATA_W): host/loader request.
REQ-007 Ports o_h_ready (out, 1), o_h_rvalid (out, 1), o_h_rdata (out, DATA_W): host grant and read return.
REQ-008 Ports i_d_valid, i_d_we, i_d_addr, i_d_wdata, o_d_ready, o_d_rvalid, o_d_rdata: processor data port, same widths as host.
REQ-009 Ports i_f_valid, i_f_addr, o_f_ready, o_f_rvalid, o_f_rdata: processor fetch port, read-only, same widths.
REQ-010 Ports o_m_en, o_m_we (out, 1), o_m_addr (out, ADDR_W), o_m_wdata (out, DATA_W), i_m_rdata (in, DATA_W): single-port synchronous RAM; read data valid one cycle after o_m_en with o_m_we=0.
REQ-011 Port o_stall  out  1  asserted when i_f_valid or i_d_valid is high and that request is not granted this cycle.

Function
REQ-012 At most one requester SHALL be granted per cycle; the grant is combinational from the current valids and registered state.
REQ-013 Default priority SHALL be host > data > fetch.
REQ-014 Counter wait_q (0..MAX_WAIT) SHALL increment, saturating at MAX_WAIT, in each cycle with i_f_valid=1 and no fetch grant; it SHALL clear on a fetch grant or when i_f_valid=0.
REQ-015 When wait_q==MAX_WAIT and i_f_valid=1, fetch SHALL win over host and data for that cycle.
REQ-016 o_X_ready SHALL equal the grant to requester X; a request transfers when valid and ready are both high.
REQ-017 On a grant: o_m_en=1, with o_m_addr, o_m_we and o_m_wdata taken from the winner (fetch drives o_m_we=0, o_m_wdata=0). With no grant, o_m_en=0 and the other memory outputs are 0.
REQ-018 A granted read SHALL assert o_X_rvalid for exactly one cycle, in the cycle after the grant, with o_X_rdata=i_m_rdata; a granted write SHALL produce no rvalid.
REQ-019 A one-deep return tag (rd_owner_q, rd_pend_q) SHALL route read data; back-to-back reads, one per cycle, SHALL be supported at full throughput.
REQ-020 o_X_rdata SHALL be 0 whenever o_X_rvalid=0.
REQ-021 A write followed by a read to the same address in the next cycle SHALL return the written data; ordering is the RAM's natural order and no bypass is added.
REQ-022 o_stall SHALL be combinational and SHALL be 0 when neither i_f_valid nor i_d_valid is high.
REQ-023 A valid with no grant SHALL have no effect on the memory; requesters hold their request until it is granted.

Reset
REQ-024 While i_rst_n=0 at a clock edge: wait_q=0, rd_pend_q=0, rd_owner_q=0; all o_X_rvalid are 0 in the next cycle.
REQ-025 During reset, all o_X_ready, o_m_en, o_m_we and o_stall SHALL be 0 regardless of the inputs.
REQ-026 A read granted in the cycle before reset asserts SHALL be discarded; no rvalid is issued after reset.

Verification
REQ-027 Fetch-only reads at 0x10, then 0x11, with the RAM holding 0xA, 0xB -> o_f_rvalid in cycles 1 and 2 with 0xA, then 0xB; o_stall=0.
REQ-028 Data write (0x20, 0xDEAD) and fetch (0x00) in the same cycle -> data granted, fetch not granted, o_stall=1; fetch granted in the next cycle.
REQ-029 Host valid held continuously with fetch valid, MAX_WAIT=4 -> fetch is denied 4 cycles and granted in cycle 5; wait_q returns to 0.
REQ-030 Data read 0x30 in cycle N, then fetch 0x31 in cycle N+1 -> o_d_rvalid only in N+1 and o_f_rvalid only in N+2, with correct data and no cross-routing.
REQ-031 i_rst_n driven low in the cycle after a data read grant -> o_d_rvalid stays 0, and all outputs are 0 during reset.
REQ-032 Host writes 0x55 to 0x7 and then reads 0x7 -> o_h_rvalid=1 with o_h_rdata=0x55, and no write rvalid is issued.

Source files
------------

// File: rtl/mem_arbiter.sv
// Three-way arbiter (host, data, fetch) in front of one single-port synchronous RAM.
// Latency: grant is combinational; read data returns one cycle after its grant.
// Backpressure: a requester holds valid until its ready is seen; fetch is forced after MAX_WAIT denials.
module mem_arbiter #(
  parameter int ADDR_W   = 18,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,

  // host / loader port
  input  logic              i_h_valid,
  input  logic              i_h_we,
  input  logic [ADDR_W-1:0] i_h_addr,
  input  logic [DATA_W-1:0] i_h_wdata,
  output logic              o_h_ready,
  output logic              o_h_rvalid,
  output logic [DATA_W-1:0] o_h_rdata,

  // processor data port
  input  logic              i_d_valid,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_ready,
  output logic              o_d_rvalid,
  output logic [DATA_W-1:0] o_d_rdata,

  // processor fetch port (read-only)
  input  logic              i_f_valid,
  input  logic [ADDR_W-1:0] i_f_addr,
  output logic              o_f_ready,
  output logic              o_f_rvalid,
  output logic [DATA_W-1:0] o_f_rdata,

  // single-port synchronous RAM
  output logic              o_m_en,
  output logic              o_m_we,
  output logic [ADDR_W-1:0] o_m_addr,
  output logic [DATA_W-1:0] o_m_wdata,
  input  logic [DATA_W-1:0] i_m_rdata,

  output logic              o_stall
);

  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  // Which requester the read currently in flight belongs to.
  typedef enum logic [1:0] {
    OWN_H = 2'd0,
    OWN_D = 2'd1,
    OWN_F = 2'd2
  } owner_e;

  logic [WAIT_W-1:0] r_wait_q;
  logic              r_rd_pend_q;
  owner_e            r_rd_owner_q;

  logic              w_force_f;
  logic              w_gnt_h;
  logic              w_gnt_d;
  logic              w_gnt_f;
  logic              w_rd_gnt;
  owner_e            w_rd_owner;
  logic              w_rd_ok;

  // A starving fetch overrides the fixed priority for one cycle.
  assign w_force_f = i_f_valid && (r_wait_q == WAIT_MAX);

  // Grant selection: forced fetch, else host > data > fetch; nothing while in reset.
  always_comb begin
    w_gnt_h = 1'b0;
    w_gnt_d = 1'b0;
    w_gnt_f = 1'b0;
    if (i_rst_n) begin
      if (w_force_f) begin
        w_gnt_f = 1'b1;
      end else if (i_h_valid) begin
        w_gnt_h = 1'b1;
      end else if (i_d_valid) begin
        w_gnt_d = 1'b1;
      end else if (i_f_valid) begin
        w_gnt_f = 1'b1;
      end
    end
  end

  assign o_h_ready = w_gnt_h;
  assign o_d_ready = w_gnt_d;
  assign o_f_ready = w_gnt_f;

  // Stall the core whenever one of its requests is waiting this cycle.
  assign o_stall = i_rst_n &&
                   ((i_f_valid && !w_gnt_f) || (i_d_valid && !w_gnt_d));

  // Steer the winner onto the RAM port; idle port is driven to all zeros.
  always_comb begin
    o_m_en    = 1'b0;
    o_m_we    = 1'b0;
    o_m_addr  = '0;
    o_m_wdata = '0;
    if (w_gnt_h) begin
      o_m_en    = 1'b1;
      o_m_we    = i_h_we;
      o_m_addr  = i_h_addr;
      o_m_wdata = i_h_wdata;
    end else if (w_gnt_d) begin
      o_m_en    = 1'b1;
      o_m_we    = i_d_we;
      o_m_addr  = i_d_addr;
      o_m_wdata = i_d_wdata;
    end else if (w_gnt_f) begin
      o_m_en    = 1'b1;
      o_m_addr  = i_f_addr;
    end
  end

  // Identify a read being issued this cycle and who it belongs to.
  always_comb begin
    w_rd_gnt   = (w_gnt_h && !i_h_we) || (w_gnt_d && !i_d_we) || w_gnt_f;
    w_rd_owner = OWN_H;
    if (w_gnt_d) begin
      w_rd_owner = OWN_D;
    end else if (w_gnt_f) begin
      w_rd_owner = OWN_F;
    end
  end

  // Fetch starvation counter: counts denied fetch cycles, saturating.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wait_q <= '0;
    end else if (!i_f_valid || w_gnt_f) begin
      r_wait_q <= '0;
    end else if (r_wait_q != WAIT_MAX) begin
      r_wait_q <= r_wait_q + 1'b1;
    end
  end

  // One-deep return tag; rewritten every cycle so back-to-back reads stream.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rd_pend_q  <= 1'b0;
      r_rd_owner_q <= OWN_H;
    end else begin
      r_rd_pend_q  <= w_rd_gnt;
      r_rd_owner_q <= w_rd_owner;
    end
  end

  // Read return is suppressed while reset is held, so a read issued just
  // before reset never surfaces.
  assign w_rd_ok    = i_rst_n && r_rd_pend_q;
  assign o_h_rvalid = w_rd_ok && (r_rd_owner_q == OWN_H);
  assign o_d_rvalid = w_rd_ok && (r_rd_owner_q == OWN_D);
  assign o_f_rvalid = w_rd_ok && (r_rd_owner_q == OWN_F);

  assign o_h_rdata  = o_h_rvalid ? i_m_rdata : '0;
  assign o_d_rdata  = o_d_rvalid ? i_m_rdata : '0;
  assign o_f_rdata  = o_f_rvalid ? i_m_rdata : '0;

  // Never more than one winner per cycle.
  a_onehot_grant : assert property (@(posedge i_clk) $onehot0({w_gnt_h, w_gnt_d, w_gnt_f}));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous RAM.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Expected values are hand-derived constants; all checks go through chk().
module tb_mem_arbiter;
  localparam int ADDR_W = 18;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst_n;
  logic              h_valid, h_we, h_ready, h_rvalid;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_wdata, h_rdata;
  logic              d_valid, d_we, d_ready, d_rvalid;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata, d_rdata;
  logic              f_valid, f_ready, f_rvalid;
  logic [ADDR_W-1:0] f_addr;
  logic [DATA_W-1:0] f_rdata;
  logic              m_en, m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata, m_rdata;
  logic              stall;

  int n_chk = 0;
  int n_err = 0;

  logic [DATA_W-1:0] ram [0:255];

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_h_valid(h_valid), .i_h_we(h_we), .i_h_addr(h_addr), .i_h_wdata(h_wdata),
    .o_h_ready(h_ready), .o_h_rvalid(h_rvalid), .o_h_rdata(h_rdata),
    .i_d_valid(d_valid), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_d_ready(d_ready), .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata),
    .i_f_valid(f_valid), .i_f_addr(f_addr),
    .o_f_ready(f_ready), .o_f_rvalid(f_rvalid), .o_f_rdata(f_rdata),
    .o_m_en(m_en), .o_m_we(m_we), .o_m_addr(m_addr), .o_m_wdata(m_wdata),
    .i_m_rdata(m_rdata), .o_stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port RAM: read data registered, valid next cycle.
  initial begin
    for (int i = 0; i < 256; i++) ram[i] <= '0;
    ram[8'h10] <= 32'h0000_000A;
    ram[8'h11] <= 32'h0000_000B;
    ram[8'h30] <= 32'h0000_3030;
    ram[8'h31] <= 32'h0000_3131;
    m_rdata    <= '0;
  end

  always @(posedge clk) begin
    if (m_en && m_we) ram[m_addr[7:0]] <= m_wdata;
    if (m_en && !m_we) m_rdata <= ram[m_addr[7:0]];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle();
    h_valid = 0; h_we = 0; h_addr = '0; h_wdata = '0;
    d_valid = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    f_valid = 0; f_addr = '0;
  endtask

  initial begin
    rst_n = 0;
    idle();

    // Reset: everything quiet even with all requesters active.
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      h_valid = 1; d_valid = 1; f_valid = 1;
      sample();
      chk("rst_h_ready", h_ready, 0);
      chk("rst_d_ready", d_ready, 0);
      chk("rst_f_ready", f_ready, 0);
      chk("rst_m_en",    m_en,    0);
      chk("rst_m_we",    m_we,    0);
      chk("rst_stall",   stall,   0);
      chk("rst_rvalids", {h_rvalid, d_rvalid, f_rvalid}, 0);
    end
    next_cycle();
    rst_n = 1;
    idle();
    sample();
    chk("post_rst_m_en", m_en, 0);
    chk("post_rst_rvalid", {h_rvalid, d_rvalid, f_rvalid}, 0);

    // Fetch-only back-to-back reads.
    next_cycle();
    f_valid = 1; f_addr = 18'h10;
    sample();
    chk("f1_ready", f_ready, 1);
    chk("f1_stall", stall, 0);
    chk("f1_m_addr", {m_en, m_we, m_addr}, {2'b10, 18'h10});
    next_cycle();
    f_addr = 18'h11;
    sample();
    chk("f2_ready", f_ready, 1);
    chk("f2_rvalid", f_rvalid, 1);
    chk("f2_rdata", f_rdata, 32'hA);
    chk("f2_stall", stall, 0);
    next_cycle();
    idle();
    sample();
    chk("f3_rvalid", f_rvalid, 1);
    chk("f3_rdata", f_rdata, 32'hB);
    chk("f3_m_en", m_en, 0);
    next_cycle();
    sample();
    chk("f4_rvalid", f_rvalid, 0);
    chk("f4_rdata", f_rdata, 0);

    // Data write beats fetch; fetch follows next cycle.
    next_cycle();
    d_valid = 1; d_we = 1; d_addr = 18'h20; d_wdata = 32'hDEAD;
    f_valid = 1; f_addr = 18'h00;
    sample();
    chk("dw_d_ready", d_ready, 1);
    chk("dw_f_ready", f_ready, 0);
    chk("dw_stall", stall, 1);
    chk("dw_m_bus", {m_we, m_addr, m_wdata}, {1'b1, 18'h20, 32'hDEAD});
    next_cycle();
    d_valid = 0; d_we = 0;
    sample();
    chk("dw_f_ready2", f_ready, 1);
    chk("dw_stall2", stall, 0);
    chk("dw_no_rvalid", d_rvalid, 0);
    chk("dw_fetch_wdata", {m_we, m_wdata}, 0);
    next_cycle();
    idle();
    sample();
    chk("dw_f_rvalid", f_rvalid, 1);
    chk("dw_f_rdata", f_rdata, 0);

    // Host > data priority.
    next_cycle();
    h_valid = 1; h_addr = 18'h30; d_valid = 1; d_addr = 18'h31;
    sample();
    chk("pri_h_ready", h_ready, 1);
    chk("pri_d_ready", d_ready, 0);
    chk("pri_stall", stall, 1);
    next_cycle();
    idle();
    sample();
    chk("pri_h_rdata", {h_rvalid, d_rvalid, h_rdata}, {2'b10, 32'h3030});

    // Fetch starvation: 4 denials, forced on the 5th, counter cleared after.
    next_cycle();
    h_valid = 1; h_addr = 18'h40; f_valid = 1; f_addr = 18'h11;
    for (int c = 1; c <= 4; c++) begin
      sample();
      chk($sformatf("st_deny%0d", c), {h_ready, f_ready, stall}, 3'b101);
      next_cycle();
    end
    sample();
    chk("st_force", {h_ready, f_ready, stall}, 3'b010);
    next_cycle();
    sample();
    chk("st_after_force", {h_ready, f_ready}, 2'b10);
    chk("st_f_rdata", {f_rvalid, h_rvalid, f_rdata}, {2'b10, 32'hB});
    for (int c = 7; c <= 9; c++) begin
      next_cycle();
      sample();
      chk($sformatf("st_redeny%0d", c), {h_ready, f_ready}, 2'b10);
    end
    next_cycle();
    sample();
    chk("st_reforce", {h_ready, f_ready}, 2'b01);
    next_cycle();
    idle();
    sample();

    // Data read then fetch read: no cross-routing.
    next_cycle();
    d_valid = 1; d_addr = 18'h30;
    sample();
    chk("x_d_ready", d_ready, 1);
    next_cycle();
    d_valid = 0; f_valid = 1; f_addr = 18'h31;
    sample();
    chk("x_n1_d", {d_rvalid, d_rdata}, {1'b1, 32'h3030});
    chk("x_n1_f", {f_rvalid, f_rdata, h_rvalid}, 0);
    next_cycle();
    idle();
    sample();
    chk("x_n2_f", {f_rvalid, f_rdata}, {1'b1, 32'h3131});
    chk("x_n2_d", {d_rvalid, d_rdata}, 0);

    // Reset right after a data read grant discards the return.
    next_cycle();
    d_valid = 1; d_addr = 18'h30;
    sample();
    chk("rr_d_ready", d_ready, 1);
    next_cycle();
    rst_n = 0; d_valid = 0; h_valid = 1; f_valid = 1;
    sample();
    chk("rr_d_rvalid", {d_rvalid, d_rdata}, 0);
    chk("rr_outs", {h_ready, d_ready, f_ready, m_en, m_we, stall, h_rvalid, f_rvalid}, 0);
    next_cycle();
    rst_n = 1;
    idle();
    sample();
    chk("rr_after", {h_rvalid, d_rvalid, f_rvalid}, 0);

    // Host write then read of the same address.
    next_cycle();
    h_valid = 1; h_we = 1; h_addr = 18'h7; h_wdata = 32'h55;
    sample();
    chk("hw_grant", {h_ready, m_we, m_addr, m_wdata}, {2'b11, 18'h7, 32'h55});
    next_cycle();
    h_we = 0; h_wdata = '0;
    sample();
    chk("hw_no_rvalid", h_rvalid, 0);
    chk("hr_grant", {h_ready, m_we}, 2'b10);
    next_cycle();
    idle();
    sample();
    chk("hr_rdata", {h_rvalid, h_rdata}, {1'b1, 32'h55});
    next_cycle();
    sample();
    chk("hr_done", {h_rvalid, h_rdata}, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
